sum_tree_pipe: RTL and testbench



---
 rtl/sum_tree_pipe_pkg.sv | 31 +++
 rtl/sum_tree_pipe_level.sv | 61 ++++++
 rtl/sum_tree_pipe.sv | 116 +++++++++++
 tb/tb_sum_tree_pipe.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sum_tree_pipe_pkg.sv
// Shared constants and elaboration helpers for the pipelined sum-tree blocks.
// Default widths live here so sibling sum blocks agree on them.
package sum_tree_pipe_pkg;

  localparam int unsigned SUM_WIDTH_DEF = 32'd32;
  localparam int unsigned SUM_CNT_W_DEF = 32'd16;
  localparam int unsigned SUM_N_IN_DEF  = 32'd8;

  // Ceiling log2, usable in constant expressions.
  function automatic int unsigned clog2_f(input int unsigned val);
    int unsigned res;
    int unsigned rem;
    res = 32'd0;
    rem = (val > 32'd0) ? (val - 32'd1) : 32'd0;
    for (int i = 0; i < 32; i++) begin
      if (rem != 32'd0) begin
        res = res + 32'd1;
        rem = rem >> 1;
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  // Number of registered adder levels needed to reduce n_in operands to one.
  function automatic int unsigned tree_levels_f(input int unsigned n_in);
    return clog2_f(n_in);
  endfunction

endpackage

// File: rtl/sum_tree_pipe_level.sv
// One registered level of the sum tree: N_PAIRS modular adders plus the
// valid/last/acc sideband that travels alongside the partial sums.
module sum_tree_level #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned N_PAIRS = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         en,
  input  logic                         in_valid,
  input  logic                         in_last,
  input  logic                         in_acc,
  input  logic [2*N_PAIRS*WIDTH-1:0]   in_data,
  output logic                         out_valid,
  output logic                         out_last,
  output logic                         out_acc,
  output logic [N_PAIRS*WIDTH-1:0]     out_data
);

  logic [N_PAIRS*WIDTH-1:0] sum_s;
  logic [N_PAIRS*WIDTH-1:0] data_r;
  logic                     valid_r;
  logic                     last_r;
  logic                     acc_r;

  // Carry-out is dropped: the sum is kept modulo 2^WIDTH.
  function automatic logic [WIDTH-1:0] add_trunc(input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b);
    return a + b;
  endfunction

  // Pairwise reduction of the previous level's partial sums.
  always_comb begin
    sum_s = '0;
    for (int p = 0; p < int'(N_PAIRS); p++) begin
      sum_s[p*WIDTH +: WIDTH] = add_trunc(in_data[(2*p)*WIDTH +: WIDTH],
                                          in_data[(2*p+1)*WIDTH +: WIDTH]);
    end
  end

  // Level register; holds everything while the pipeline is stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_r  <= '0;
      valid_r <= 1'b0;
      last_r  <= 1'b0;
      acc_r   <= 1'b0;
    end else if (en) begin
      data_r  <= sum_s;
      valid_r <= in_valid;
      last_r  <= in_last;
      acc_r   <= in_acc;
    end
  end

  assign out_data  = data_r;
  assign out_valid = valid_r;
  assign out_last  = last_r;
  assign out_acc   = acc_r;

endmodule

// File: rtl/sum_tree_pipe.sv
// Pipelined N_IN-operand modular sum with optional per-packet accumulation,
// on valid/ready streams; one register per tree level plus an output stage.
module sum_tree_pipe
  import sum_tree_pipe_pkg::*;
#(
  parameter int unsigned WIDTH = SUM_WIDTH_DEF,
  parameter int unsigned N_IN  = SUM_N_IN_DEF,
  parameter int unsigned CNT_W = SUM_CNT_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [N_IN*WIDTH-1:0]   in_data,
  input  logic                    in_last,
  input  logic                    in_acc,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic [CNT_W-1:0]        out_count
);

  localparam int unsigned LEVELS = tree_levels_f(N_IN);
  // All stages packed back to back: stage s starts at operand 2*N_IN - 2*(N_IN>>s).
  localparam int unsigned TREE_W = (2*N_IN - 1) * WIDTH;
  localparam int unsigned ROOT_LO = (2*N_IN - 2) * WIDTH;

  logic                en_s;
  logic [TREE_W-1:0]   tree_s;
  logic [LEVELS:0]     valid_s;
  logic [LEVELS:0]     last_s;
  logic [LEVELS:0]     acc_s;
  logic [WIDTH-1:0]    root_s;
  logic [WIDTH-1:0]    acc_sum_s;
  logic [CNT_W-1:0]    cnt_inc_s;

  logic [WIDTH-1:0]    acc_r;
  logic [CNT_W-1:0]    cnt_r;
  logic [WIDTH-1:0]    out_data_r;
  logic [CNT_W-1:0]    out_count_r;
  logic                out_valid_r;

  assign en_s     = !out_valid_r || out_ready;
  assign in_ready = en_s;

  assign tree_s[N_IN*WIDTH-1:0] = in_data;
  assign valid_s[0]             = in_valid;
  assign last_s[0]              = in_last;
  assign acc_s[0]               = in_acc;

  for (genvar g = 1; g <= int'(LEVELS); g++) begin : g_level
    localparam int unsigned NP      = N_IN >> g;
    localparam int unsigned IN_LO   = (2*N_IN - 2*(N_IN >> (g-1))) * WIDTH;
    localparam int unsigned OUT_LO  = (2*N_IN - 2*(N_IN >> g)) * WIDTH;

    sum_tree_level #(
      .WIDTH   (WIDTH),
      .N_PAIRS (NP)
    ) u_level (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (en_s),
      .in_valid  (valid_s[g-1]),
      .in_last   (last_s[g-1]),
      .in_acc    (acc_s[g-1]),
      .in_data   (tree_s[IN_LO +: 2*NP*WIDTH]),
      .out_valid (valid_s[g]),
      .out_last  (last_s[g]),
      .out_acc   (acc_s[g]),
      .out_data  (tree_s[OUT_LO +: NP*WIDTH])
    );
  end

  assign root_s = tree_s[ROOT_LO +: WIDTH];

  // Packet running sum and beat count, both wrapping.
  always_comb begin
    acc_sum_s = acc_r + root_s;
    cnt_inc_s = cnt_r + CNT_W'(1);
  end

  // Output/accumulator stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_r       <= '0;
      cnt_r       <= '0;
      out_data_r  <= '0;
      out_count_r <= '0;
      out_valid_r <= 1'b0;
    end else if (en_s) begin
      if (!valid_s[LEVELS]) begin
        out_valid_r <= 1'b0;
      end else if (!acc_s[LEVELS]) begin
        // Standalone beat: an open packet is left untouched.
        out_data_r  <= root_s;
        out_count_r <= CNT_W'(1);
        out_valid_r <= 1'b1;
      end else if (!last_s[LEVELS]) begin
        acc_r       <= acc_sum_s;
        cnt_r       <= cnt_inc_s;
        out_valid_r <= 1'b0;
      end else begin
        out_data_r  <= acc_sum_s;
        out_count_r <= cnt_inc_s;
        out_valid_r <= 1'b1;
        acc_r       <= '0;
        cnt_r       <= '0;
      end
    end
  end

  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign out_count = out_count_r;

endmodule

// File: tb/tb_sum_tree_pipe.sv
// Self-checking bench for sum_tree_pipe: transaction-level model of beat sums
// and packet accumulation, directed scenarios plus randomized traffic.
module tb_sum_tree_pipe;

  localparam int W = 32;
  localparam int N = 8;
  localparam int C = 16;

  logic           clk;
  logic           rst_n;
  logic           in_valid;
  logic           in_ready;
  logic [N*W-1:0] in_data;
  logic           in_last;
  logic           in_acc;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   out_data;
  logic [C-1:0]   out_count;

  sum_tree_pipe #(.WIDTH(W), .N_IN(N), .CNT_W(C)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_acc    (in_acc),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_count (out_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] d;
    logic [C-1:0] c;
    int           cyc;
  } res_t;

  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   last_acc_cyc = 0;
  res_t exp_q[$];
  res_t got_q[$];
  logic [W-1:0] m_acc = '0;
  logic [C-1:0] m_cnt = '0;
  bit           stalled = 1'b0;
  logic [W-1:0] held_d;
  logic [C-1:0] held_c;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [W-1:0] beat_sum(input logic [N*W-1:0] v);
    logic [W-1:0] s;
    s = '0;
    for (int k = 0; k < N; k++) s = s + v[k*W +: W];
    return s;
  endfunction

  function automatic logic [N*W-1:0] mk_ops(input logic [W-1:0] off);
    logic [N*W-1:0] v;
    for (int k = 0; k < N; k++) v[k*W +: W] = 32'(k + 1) + off;
    return v;
  endfunction

  // Monitor: model update on accepted beats, comparison on every delivered result.
  always @(negedge clk) begin
    res_t e;
    res_t g;
    logic [W-1:0] t;
    cyc++;
    if (!rst_n) begin
      exp_q.delete();
      m_acc = '0;
      m_cnt = '0;
      stalled = 1'b0;
      chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
    end else begin
      chk("in_ready_rule", {31'd0, in_ready}, {31'd0, (!out_valid || out_ready)});
      if (stalled) begin
        chk("stall_valid", {31'd0, out_valid}, 32'd1);
        chk("stall_data", out_data, held_d);
        chk("stall_count", {16'd0, out_count}, {16'd0, held_c});
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_result: got data 0x%08h count %0d with nothing expected", out_data, out_count);
        end else begin
          e = exp_q.pop_front();
          chk("out_data", out_data, e.d);
          chk("out_count", {16'd0, out_count}, {16'd0, e.c});
        end
        g.d = out_data;
        g.c = out_count;
        g.cyc = cyc;
        got_q.push_back(g);
      end
      stalled = out_valid && !out_ready;
      held_d = out_data;
      held_c = out_count;
      if (in_valid && in_ready) begin
        last_acc_cyc = cyc;
        t = beat_sum(in_data);
        if (!in_acc) begin
          e.d = t; e.c = 16'd1; e.cyc = cyc;
          exp_q.push_back(e);
        end else if (!in_last) begin
          m_acc = m_acc + t;
          m_cnt = m_cnt + 16'd1;
        end else begin
          e.d = m_acc + t; e.c = m_cnt + 16'd1; e.cyc = cyc;
          exp_q.push_back(e);
          m_acc = '0;
          m_cnt = '0;
        end
      end
    end
  end

  // Called right after a rising edge; returns right after the accepting edge.
  task automatic send_beat(input logic [N*W-1:0] d, input logic acc, input logic last);
    bit ok;
    int n;
    in_data = d; in_acc = acc; in_last = last; in_valid = 1'b1;
    ok = 1'b0; n = 0;
    while (!ok && n < 200) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!ok) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles", n);
    end
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N*W-1:0] v;
    bit done;
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0; in_acc = 1'b0; out_ready = 1'b1;
    idle(3);
    @(negedge clk);
    chk("reset_out_data", out_data, 32'd0);
    chk("reset_out_count", {16'd0, out_count}, 32'd0);
    chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(2);

    // Standalone latency
    got_q.delete();
    send_beat(mk_ops(32'd0), 1'b0, 1'b0);
    idle(12);
    chk("lat_n", 32'(got_q.size()), 32'd1);
    if (got_q.size() >= 1) begin
      chk("lat_data", got_q[0].d, 32'd36);
      chk("lat_count", {16'd0, got_q[0].c}, 32'd1);
      chk("lat_cycles", 32'(got_q[0].cyc - last_acc_cyc), 32'd4);
    end

    // Wrap-around
    got_q.delete();
    for (int k = 0; k < N; k++) v[k*W +: W] = 32'hFFFF_FFFF;
    send_beat(v, 1'b0, 1'b0);
    v = '0;
    v[31:0] = 32'h8000_0000;
    v[63:32] = 32'h8000_0000;
    send_beat(v, 1'b0, 1'b0);
    idle(12);
    chk("wrap_n", 32'(got_q.size()), 32'd2);
    if (got_q.size() >= 2) begin
      chk("wrap_all_ones", got_q[0].d, 32'hFFFF_FFF8);
      chk("wrap_msb_pair", got_q[1].d, 32'd0);
    end

    // Three-beat packet
    got_q.delete();
    send_beat(mk_ops(32'd0), 1'b1, 1'b0);
    send_beat(mk_ops(32'd0), 1'b1, 1'b0);
    send_beat(mk_ops(32'd0), 1'b1, 1'b1);
    idle(12);
    chk("pkt_n", 32'(got_q.size()), 32'd1);
    if (got_q.size() >= 1) begin
      chk("pkt_data", got_q[0].d, 32'd108);
      chk("pkt_count", {16'd0, got_q[0].c}, 32'd3);
    end

    // Backpressure mid-stream
    got_q.delete();
    fork
      begin
        for (int i = 0; i < 6; i++) send_beat(mk_ops(32'(i)), 1'b0, 1'b0);
      end
      begin
        idle(3);
        out_ready = 1'b0;
        idle(5);
        out_ready = 1'b1;
      end
    join
    idle(15);
    chk("bp_n", 32'(got_q.size()), 32'd6);
    for (int i = 0; i < 6 && i < got_q.size(); i++)
      chk("bp_order", got_q[i].d, 32'd36 + 32'(8 * i));

    // Interleaved standalone beat inside an open packet
    got_q.delete();
    send_beat(mk_ops(32'd0), 1'b1, 1'b0);
    v = '0;
    v[31:0] = 32'd100;
    send_beat(v, 1'b0, 1'b0);
    send_beat(mk_ops(32'd0), 1'b1, 1'b1);
    idle(12);
    chk("ilv_n", 32'(got_q.size()), 32'd2);
    if (got_q.size() >= 2) begin
      chk("ilv_standalone_data", got_q[0].d, 32'd100);
      chk("ilv_standalone_count", {16'd0, got_q[0].c}, 32'd1);
      chk("ilv_packet_data", got_q[1].d, 32'd72);
      chk("ilv_packet_count", {16'd0, got_q[1].c}, 32'd2);
    end

    // Reset in the middle of a packet
    send_beat(mk_ops(32'd0), 1'b1, 1'b0);
    send_beat(mk_ops(32'd0), 1'b1, 1'b0);
    idle(6);
    rst_n = 1'b0;
    #1;
    chk("rst_immediate_valid", {31'd0, out_valid}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    got_q.delete();
    send_beat(mk_ops(32'd0), 1'b1, 1'b1);
    idle(12);
    chk("rst_n_results", 32'(got_q.size()), 32'd1);
    if (got_q.size() >= 1) begin
      chk("rst_pkt_data", got_q[0].d, 32'd36);
      chk("rst_pkt_count", {16'd0, got_q[0].c}, 32'd1);
    end

    // Randomized traffic with random backpressure
    done = 1'b0;
    fork
      begin
        for (int b = 0; b < 1500; b++) begin
          for (int k = 0; k < N; k++) v[k*W +: W] = $urandom();
          send_beat(v, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0));
          if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
        end
        send_beat(mk_ops(32'd0), 1'b1, 1'b1);
        done = 1'b1;
      end
      begin
        while (!done) begin
          out_ready = ($urandom_range(0, 3) != 0);
          idle(1);
        end
        out_ready = 1'b1;
      end
    join
    idle(20);
    chk("final_drain", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
